gamepad_poller: RTL and testbench

//  Sequences the 3-button DB9 gamepad port (pin0-3 U/D/L/R, pin5 B/A, pin8 C/Start, pin6 select out).

---
 rtl/gamepad_poller_pkg.sv | 23 ++
 rtl/gamepad_poller_pin_sync.sv | 22 ++
 rtl/gamepad_poller.sv | 175 +++++++++++++++++
 tb/tb_gamepad_poller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gamepad_poller_pkg.sv
// Shared definitions for the 3-button pad poller: FSM state codes and button bit
// indices. The CPU button register uses the same bit indices.
package gamepad_poller_pkg;

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] SEL_HI = 4'd1;
    localparam logic [3:0] SEL_LO = 4'd2;
    localparam logic [3:0] COMMIT = 4'd3;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_B     = 4;
    localparam int BTN_C     = 5;
    localparam int BTN_A     = 6;
    localparam int BTN_START = 7;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/gamepad_poller_pin_sync.sv
// Two-flop synchronizer for one raw pad line; resets high to match an idle pad pin.
module gamepad_poller_pin_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            // NOTE: non-blocking so q takes the old meta, giving two real flop stages.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gamepad_poller.sv
// Polls a 3-button DB9 pad: toggles select, samples both halves, debounces across
// polls and publishes an active-high button byte with press/release pulses.
module gamepad_poller #(
    parameter int unsigned POLL_DIV = 50000,
    parameter int unsigned SETTLE   = 16,
    parameter int unsigned DEBOUNCE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pin0,
    input  logic       pin1,
    input  logic       pin2,
    input  logic       pin3,
    input  logic       pin5,
    input  logic       pin8,
    input  logic       poll_now,
    output logic       pin6,
    output logic [7:0] buttons,
    output logic [7:0] pressed,
    output logic [7:0] released,
    output logic       present,
    output logic [3:0] curr
);

    import gamepad_poller_pkg::*;

    localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int CW = $clog2(SETTLE);
    localparam logic [TW-1:0] TMR_MAX = TW'(POLL_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE - 1);
    localparam logic [3:0]    DEB_MIN = 4'(DEBOUNCE);

    // Synced pad lines, index order {pin8, pin5, pin3, pin2, pin1, pin0}.
    logic [5:0] pad_raw;
    logic [5:0] pad_s;

    assign pad_raw = {pin8, pin5, pin3, pin2, pin1, pin0};

    for (genvar i = 0; i < 6; i++) begin : g_sync
        gamepad_poller_pin_sync u_pin_sync (
            .clk   (clk),
            .reset (reset),
            .d     (pad_raw[i]),
            .q     (pad_s[i])
        );
    end

    logic [TW-1:0] tmr;
    logic          tick;
    logic          req;

    assign tick = (tmr == TMR_MAX);
    assign req  = tick | poll_now;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr <= '0;
        end else begin
            tmr <= tick ? '0 : tmr + 1'b1;
        end
    end

    logic          pending;
    logic [CW-1:0] cnt;
    logic [5:0]    hi_q;
    logic          a_q;
    logic          start_q;
    logic          det_q;
    logic [7:0]    last_cand;
    logic [3:0]    stable;

    logic [7:0] btn_n;
    logic [7:0] cand;
    logic [3:0] stable_n;
    logic       take;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        btn_n            = '1;
        btn_n[BTN_UP]    = hi_q[0];
        btn_n[BTN_DOWN]  = hi_q[1];
        btn_n[BTN_LEFT]  = hi_q[2];
        btn_n[BTN_RIGHT] = hi_q[3];
        btn_n[BTN_B]     = hi_q[4];
        btn_n[BTN_C]     = hi_q[5];
        btn_n[BTN_A]     = a_q;
        btn_n[BTN_START] = start_q;

        cand     = det_q ? ~btn_n : 8'h00;
        stable_n = (cand == last_cand) ? sat_inc(stable) : 4'd1;
        take     = (stable_n >= DEB_MIN) && (cand != buttons);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curr      <= IDLE;
            pin6      <= 1'b1;
            pending   <= 1'b0;
            cnt       <= '0;
            hi_q      <= '1;
            a_q       <= 1'b1;
            start_q   <= 1'b1;
            det_q     <= 1'b0;
            last_cand <= '0;
            stable    <= '0;
            buttons   <= '0;
            pressed   <= '0;
            released  <= '0;
            present   <= 1'b0;
        end else begin
            pressed  <= '0;
            released <= '0;

            // A request arriving while the pending one is consumed starts the next poll.
            if (curr == IDLE && pending) begin
                pending <= req;
            end else begin
                pending <= pending | req;
            end

            case (curr)
                IDLE: begin
                    pin6 <= 1'b1;
                    if (pending) begin
                        curr <= SEL_HI;
                        cnt  <= '0;
                    end
                end

                SEL_HI: begin
                    if (cnt == CNT_MAX) begin
                        hi_q <= pad_s;
                        cnt  <= '0;
                        pin6 <= 1'b0;
                        curr <= SEL_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SEL_LO: begin
                    if (cnt == CNT_MAX) begin
                        a_q     <= pad_s[4];
                        start_q <= pad_s[5];
                        // A real 3-button pad pulls Left and Right low while select is low.
                        det_q   <= ~pad_s[2] & ~pad_s[3];
                        cnt     <= '0;
                        pin6    <= 1'b1;
                        curr    <= COMMIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                COMMIT: begin
                    present   <= det_q;
                    last_cand <= cand;
                    stable    <= stable_n;
                    if (take) begin
                        buttons  <= cand;
                        pressed  <= cand & ~buttons;
                        released <= ~cand & buttons;
                    end
                    curr <= IDLE;
                end

                default: begin
                    pin6 <= 1'b1;
                    curr <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gamepad_poller.sv
// Bench for gamepad_poller: a 3-button pad model answers the select line, and a
// poll-level model predicts every output on every cycle.
module tb_gamepad_poller;

    localparam int POLL_DIV = 64;
    localparam int SETTLE   = 4;
    localparam int DEBOUNCE = 2;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       poll_now = 1'b0;
    logic       plugged  = 1'b0;
    logic [7:0] pad_btn  = 8'h00;

    logic       pin0, pin1, pin2, pin3, pin5, pin8;
    logic       pin6;
    logic [7:0] buttons, pressed, released;
    logic       present;
    logic [3:0] curr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Pad model: active-low lines, bits {Start,A,C,B,Right,Left,Down,Up}; unplugged floats high.
    assign pin0 = ~plugged | ~pad_btn[0];
    assign pin1 = ~plugged | ~pad_btn[1];
    assign pin2 = ~plugged | (pin6 ? ~pad_btn[2] : 1'b0);
    assign pin3 = ~plugged | (pin6 ? ~pad_btn[3] : 1'b0);
    assign pin5 = ~plugged | (pin6 ? ~pad_btn[4] : ~pad_btn[6]);
    assign pin8 = ~plugged | (pin6 ? ~pad_btn[5] : ~pad_btn[7]);

    gamepad_poller #(
        .POLL_DIV (POLL_DIV),
        .SETTLE   (SETTLE),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pin0     (pin0),
        .pin1     (pin1),
        .pin2     (pin2),
        .pin3     (pin3),
        .pin5     (pin5),
        .pin8     (pin8),
        .poll_now (poll_now),
        .pin6     (pin6),
        .buttons  (buttons),
        .pressed  (pressed),
        .released (released),
        .present  (present),
        .curr     (curr)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Poll-level model: m_e counts edges since reset release, a poll starting at
    // edge s occupies edges s..s+2*SETTLE and publishes its result at edge s+2*SETTLE+1.
    int         m_e      = 0;
    int         m_start  = -100;
    bit         m_pend   = 1'b0;
    int         m_polls  = 0;
    logic [7:0] m_btn    = 8'h00;
    logic [7:0] m_pr     = 8'h00;
    logic [7:0] m_rl     = 8'h00;
    logic       m_present = 1'b0;
    logic [7:0] m_hist[$];

    always @(posedge clk or negedge reset) begin : model
        bit         req;
        bit         busy;
        bit         agree;
        logic [7:0] cand;
        if (!reset) begin
            m_e       = 0;
            m_start   = -100;
            m_pend    = 1'b0;
            m_btn     = 8'h00;
            m_pr      = 8'h00;
            m_rl      = 8'h00;
            m_present = 1'b0;
            m_hist.delete();
        end else begin
            m_e++;
            req  = poll_now || (((m_e - 1) % POLL_DIV) == POLL_DIV - 1);
            busy = (m_e - 1 >= m_start) && (m_e - 1 <= m_start + 2 * SETTLE);
            m_pr = 8'h00;
            m_rl = 8'h00;
            if (m_e == m_start + 2 * SETTLE + 1) begin
                cand      = plugged ? pad_btn : 8'h00;
                m_present = plugged;
                m_hist.push_back(cand);
                if (m_hist.size() > DEBOUNCE) void'(m_hist.pop_front());
                agree = (m_hist.size() == DEBOUNCE);
                foreach (m_hist[k]) if (m_hist[k] != cand) agree = 1'b0;
                if (agree && cand != m_btn) begin
                    m_pr  = cand & ~m_btn;
                    m_rl  = ~cand & m_btn;
                    m_btn = cand;
                end
                m_polls++;
            end
            if (!busy && m_pend) begin
                m_start = m_e;
                m_pend  = req;
            end else begin
                m_pend = m_pend | req;
            end
        end
    end

    function automatic logic [3:0] exp_curr();
        int d = m_e - m_start;
        if (d >= 0 && d < SETTLE) return 4'd1;
        if (d >= SETTLE && d < 2 * SETTLE) return 4'd2;
        if (d == 2 * SETTLE) return 4'd3;
        return 4'd0;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_pin6", 8'(pin6), 8'h01);
            check("rst_curr", 8'(curr), 8'h00);
            check("rst_buttons", buttons, 8'h00);
            check("rst_pressed", pressed, 8'h00);
            check("rst_released", released, 8'h00);
            check("rst_present", 8'(present), 8'h00);
        end else begin
            check("curr", 8'(curr), 8'(exp_curr()));
            check("pin6", 8'(pin6), (exp_curr() == 4'd2) ? 8'h00 : 8'h01);
            check("buttons", buttons, m_btn);
            check("pressed", pressed, m_pr);
            check("released", released, m_rl);
            check("present", 8'(present), 8'(m_present));
        end
    end

    logic [3:0] prev_curr      = 4'd0;
    int         sel_hi_entries = 0;

    always @(negedge clk) begin
        if (curr == 4'd1 && prev_curr != 4'd1) sel_hi_entries++;
        prev_curr = curr;
    end

    task automatic wait_polls(input int n);
        int target = m_polls + n;
        int budget = n * 4 * POLL_DIV;
        while (m_polls < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (m_polls < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_polls: got %0d polls expected %0d", m_polls, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int walk[10] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 0};
        int base;
        int guard;

        // Reset held with a plugged pad mashing random buttons.
        plugged = 1'b1;
        repeat (5) begin
            @(negedge clk);
            pad_btn = 8'($urandom);
        end
        plugged = 1'b0;
        pad_btn = 8'h00;
        #2 reset = 1'b1;

        // No pad: first timer poll enters SEL_HI at edge POLL_DIV+1.
        repeat (65) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("walk_%0d", i), 8'(curr), 8'(walk[i]));
            @(negedge clk);
        end
        wait_polls(2);
        check("nopad_present", 8'(present), 8'h00);
        check("nopad_buttons", buttons, 8'h00);

        // Up + A held.
        plugged = 1'b1;
        pad_btn = 8'h41;
        wait_polls(1);
        check("ua_poll1_buttons", buttons, 8'h00);
        check("ua_poll1_present", 8'(present), 8'h01);
        wait_polls(1);
        check("ua_poll2_buttons", buttons, 8'h41);
        check("ua_poll2_pressed", pressed, 8'h41);
        @(negedge clk);
        check("ua_pressed_drop", pressed, 8'h00);
        wait_polls(1);
        check("ua_poll3_pressed", pressed, 8'h00);

        // Start glitches in for a single poll.
        pad_btn = 8'hC1;
        wait_polls(1);
        check("start_glitch_buttons", buttons, 8'h41);
        pad_btn = 8'h41;
        wait_polls(2);
        check("start_after_buttons", buttons, 8'h41);
        check("start_after_pressed", pressed, 8'h00);
        check("start_after_released", released, 8'h00);

        // Release everything.
        pad_btn = 8'h00;
        wait_polls(1);
        check("rel_poll1_buttons", buttons, 8'h41);
        wait_polls(1);
        check("rel_poll2_buttons", buttons, 8'h00);
        check("rel_poll2_released", released, 8'h41);
        @(negedge clk);
        check("rel_released_drop", released, 8'h00);

        // Hold Up + A again, then pull the pad.
        pad_btn = 8'h41;
        wait_polls(2);
        check("replug_buttons", buttons, 8'h41);
        plugged = 1'b0;
        wait_polls(1);
        check("unplug_poll1_buttons", buttons, 8'h41);
        check("unplug_poll1_present", 8'(present), 8'h00);
        wait_polls(1);
        check("unplug_poll2_buttons", buttons, 8'h00);
        check("unplug_poll2_released", released, 8'h41);

        // poll_now on the wrap cycle, then two more requests while that poll runs.
        guard = 0;
        while ((m_e % POLL_DIV) != POLL_DIV - 1 && guard < 4 * POLL_DIV) begin
            @(negedge clk);
            guard++;
        end
        poll_now = 1'b1;
        base     = sel_hi_entries;
        @(negedge clk) poll_now = 1'b0;
        @(negedge clk) poll_now = 1'b1;
        @(negedge clk) poll_now = 1'b0;
        @(negedge clk) poll_now = 1'b1;
        @(negedge clk) poll_now = 1'b0;
        repeat (6) @(negedge clk);
        check("wrap_sel_hi_entries", 8'(sel_hi_entries - base), 8'h01);
        repeat (29) @(negedge clk);
        check("busy_sel_hi_entries", 8'(sel_hi_entries - base), 8'h02);

        // Commit Up + A, then reset in the middle of the next select-low phase.
        plugged = 1'b1;
        pad_btn = 8'h41;
        wait_polls(2);
        check("pre_reset_buttons", buttons, 8'h41);
        guard = 0;
        while (exp_curr() != 4'd2 && guard < 4 * POLL_DIV) begin
            @(negedge clk);
            guard++;
        end
        #2 reset = 1'b0;
        #1;
        check("midpoll_pin6", 8'(pin6), 8'h01);
        check("midpoll_curr", 8'(curr), 8'h00);
        check("midpoll_buttons", buttons, 8'h00);
        check("midpoll_present", 8'(present), 8'h00);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        wait_polls(2);
        check("post_reset_buttons", buttons, 8'h41);
        check("post_reset_pressed", pressed, 8'h41);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
